// File: rtl/branch_predictor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// branch_predictor : IF-stage direct-mapped BTB with 2-bit bimodal counters,
//                    trained by the ID-stage branch resolution.
// Revision 1.0
// ----------------------------------------------------------------------------
module branch_predictor #(
  parameter int WIDTH_PC   = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH_PC-1:0] pc_IF,
  output logic                predTaken,
  output logic [WIDTH_PC-1:0] predPC,
  input  logic                id_valid,
  input  logic                id_stall,
  input  logic [WIDTH_PC-1:0] pc_ID,
  input  logic                upd_branch,
  input  logic                upd_isB,
  input  logic                upd_taken,
  input  logic [WIDTH_PC-1:0] upd_target,
  input  logic                upd_predTaken,
  input  logic [WIDTH_PC-1:0] upd_predPC,
  output logic                mispredict,
  output logic [WIDTH_PC-1:0] redirectPC,
  output logic [31:0]         br_cnt,
  output logic [31:0]         miss_cnt
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = WIDTH_PC - INDEX_BITS - 2;

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [WIDTH_PC-1:0] target_q [ENTRIES];
  logic                jalr_q   [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  logic [INDEX_BITS-1:0] w_if_idx, w_id_idx;
  logic [TAG_W-1:0]      w_if_tag, w_id_tag;
  logic                  w_if_hit, w_id_hit, w_chk, w_misp;
  logic [WIDTH_PC-1:0]   w_id_seq;

  logic                wr_en_d;
  logic                ent_valid_d;
  logic [TAG_W-1:0]    ent_tag_d;
  logic [WIDTH_PC-1:0] ent_target_d;
  logic                ent_jalr_d;
  logic [1:0]          ent_ctr_d;

  assign w_if_idx = pc_IF[INDEX_BITS+1:2];
  assign w_if_tag = pc_IF[WIDTH_PC-1:INDEX_BITS+2];
  assign w_id_idx = pc_ID[INDEX_BITS+1:2];
  assign w_id_tag = pc_ID[WIDTH_PC-1:INDEX_BITS+2];

  assign w_if_hit = valid_q[w_if_idx] && (tag_q[w_if_idx] == w_if_tag);
  assign w_id_hit = valid_q[w_id_idx] && (tag_q[w_id_idx] == w_id_tag);

  // jalr entries predict taken unconditionally; the counter only steers B-types
  assign predTaken = w_if_hit && (jalr_q[w_if_idx] || ctr_q[w_if_idx][1]);
  assign predPC    = predTaken ? target_q[w_if_idx] : pc_IF + WIDTH_PC'(4);

  assign w_chk    = id_valid && !id_stall;
  assign w_id_seq = pc_ID + WIDTH_PC'(4);

  always_comb begin
    w_misp = 1'b0;
    if (w_chk) begin
      if (upd_branch) begin
        w_misp = (upd_taken != upd_predTaken) ||
                 (upd_taken && (upd_target != upd_predPC));
      end else begin
        w_misp = upd_predTaken;
      end
    end
  end

  assign mispredict = w_misp;
  assign redirectPC = (upd_branch && upd_taken) ? upd_target : w_id_seq;

  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (w_chk && upd_branch) br_cnt_d = br_cnt_q + 32'd1;
    if (w_misp)              miss_cnt_d = miss_cnt_q + 32'd1;
  end

  assign br_cnt   = br_cnt_q;
  assign miss_cnt = miss_cnt_q;

  always_comb begin
    wr_en_d      = 1'b0;
    ent_valid_d  = valid_q[w_id_idx];
    ent_tag_d    = tag_q[w_id_idx];
    ent_target_d = target_q[w_id_idx];
    ent_jalr_d   = jalr_q[w_id_idx];
    ent_ctr_d    = ctr_q[w_id_idx];
    if (w_chk) begin
      if (upd_branch) begin
        if (w_id_hit) begin
          wr_en_d = 1'b1;
          if (upd_isB) begin
            if (upd_taken) begin
              ent_target_d = upd_target;
              if (ent_ctr_d != 2'b11) ent_ctr_d = ent_ctr_d + 2'd1;
            end else if (ent_ctr_d != 2'b00) begin
              ent_ctr_d = ent_ctr_d - 2'd1;
            end
          end else begin
            ent_target_d = upd_target;
          end
        end else if (upd_taken) begin
          wr_en_d      = 1'b1;
          ent_valid_d  = 1'b1;
          ent_tag_d    = w_id_tag;
          ent_target_d = upd_target;
          ent_jalr_d   = !upd_isB;
          ent_ctr_d    = 2'b10;
        end
      end else if (w_id_hit) begin
        // a non-branch hitting the BTB is an alias; drop the stale entry
        wr_en_d     = 1'b1;
        ent_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
      br_cnt_q   <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (wr_en_d) begin
        valid_q[w_id_idx]  <= ent_valid_d;
        tag_q[w_id_idx]    <= ent_tag_d;
        target_q[w_id_idx] <= ent_target_d;
        jalr_q[w_id_idx]   <= ent_jalr_d;
        ctr_q[w_id_idx]    <= ent_ctr_d;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_branch_predictor : directed vector bench for branch_predictor.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_IF, pc_ID, upd_target, upd_predPC;
  logic        id_valid, id_stall, upd_branch, upd_isB, upd_taken, upd_predTaken;
  logic        predTaken, mispredict;
  logic [31:0] predPC, redirectPC, br_cnt, miss_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor #(.WIDTH_PC(32), .INDEX_BITS(6)) dut (
    .clk(clk), .rst(rst), .pc_IF(pc_IF), .predTaken(predTaken), .predPC(predPC),
    .id_valid(id_valid), .id_stall(id_stall), .pc_ID(pc_ID),
    .upd_branch(upd_branch), .upd_isB(upd_isB), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_predTaken(upd_predTaken), .upd_predPC(upd_predPC),
    .mispredict(mispredict), .redirectPC(redirectPC), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct {
    logic [31:0] pcif;
    logic        v, s;
    logic [31:0] pcid;
    logic        br, isb, tk;
    logic [31:0] tgt;
    logic        pt;
    logic [31:0] ppc;
    logic        e_pt;
    logic [31:0] e_ppc;
    logic        e_misp;
    logic [31:0] e_redir, e_br, e_miss;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] pcif, input logic v, input logic s,
                     input logic [31:0] pcid, input logic br, input logic isb,
                     input logic tk, input logic [31:0] tgt, input logic pt,
                     input logic [31:0] ppc, input logic e_pt, input logic [31:0] e_ppc,
                     input logic e_misp, input logic [31:0] e_redir,
                     input logic [31:0] e_br, input logic [31:0] e_miss);
    vec_t x;
    x.pcif = pcif; x.v = v; x.s = s; x.pcid = pcid; x.br = br; x.isb = isb;
    x.tk = tk; x.tgt = tgt; x.pt = pt; x.ppc = ppc; x.e_pt = e_pt; x.e_ppc = e_ppc;
    x.e_misp = e_misp; x.e_redir = e_redir; x.e_br = e_br; x.e_miss = e_miss;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic [31:0] pcif, input logic v, input logic s,
                       input logic [31:0] pcid, input logic br, input logic isb,
                       input logic tk, input logic [31:0] tgt, input logic pt,
                       input logic [31:0] ppc);
    pc_IF = pcif; id_valid = v; id_stall = s; pc_ID = pcid; upd_branch = br;
    upd_isB = isb; upd_taken = tk; upd_target = tgt; upd_predTaken = pt; upd_predPC = ppc;
  endtask

  initial begin
    // pc_IF, v, s, pc_ID, br, isB, tk, tgt, pT, pPC | predT, predPC, misp, redir, br_cnt, miss_cnt
    add(32'h100, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h4,   0, 0);
    add(32'h100, 1, 0, 32'h100, 1, 1, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80,  0, 0);
    add(32'h100, 1, 0, 32'h100, 1, 1, 0, 32'h80,  1, 32'h80,  1, 32'h80,  1, 32'h104, 1, 1);
    add(32'h100, 1, 0, 32'h100, 1, 1, 0, 32'h80,  0, 32'h104, 0, 32'h104, 0, 32'h104, 2, 2);
    add(32'h100, 1, 0, 32'h100, 1, 1, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80,  3, 2);
    add(32'h100, 1, 0, 32'h100, 1, 1, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80,  4, 3);
    add(32'h100, 1, 0, 32'h100, 1, 1, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80,  5, 4);
    add(32'h100, 1, 0, 32'h100, 1, 1, 1, 32'h84,  1, 32'h80,  1, 32'h80,  1, 32'h84,  6, 4);
    add(32'h100, 1, 0, 32'h100, 1, 1, 0, 32'h84,  1, 32'h84,  1, 32'h84,  1, 32'h104, 7, 5);
    add(32'h100, 1, 0, 32'h200, 1, 0, 1, 32'h400, 0, 32'h204, 1, 32'h84,  1, 32'h400, 8, 6);
    add(32'h200, 1, 0, 32'h200, 1, 0, 1, 32'h500, 1, 32'h400, 1, 32'h400, 1, 32'h500, 9, 7);
    add(32'h200, 1, 0, 32'h200, 1, 1, 0, 32'h500, 1, 32'h500, 1, 32'h500, 1, 32'h204, 10, 8);
    add(32'h200, 1, 0, 32'h200, 0, 0, 0, 32'h0,   1, 32'h500, 1, 32'h500, 1, 32'h204, 11, 9);
    add(32'h200, 0, 0, 32'h100, 1, 1, 1, 32'h80,  0, 32'h104, 0, 32'h204, 0, 32'h80,  11, 10);
    add(32'h100, 1, 0, 32'h300, 0, 0, 0, 32'h0,   0, 32'h304, 0, 32'h104, 0, 32'h304, 11, 10);
    add(32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 11, 10);
    add(32'h40,  1, 0, 32'h40,  1, 1, 0, 32'h99,  0, 32'h44,  0, 32'h44,  0, 32'h44,  11, 10);
    add(32'h40,  0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 32'h4,   12, 10);

    rst = 1'b1;
    drive(32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].pcif, vecs[i].v, vecs[i].s, vecs[i].pcid, vecs[i].br, vecs[i].isb,
            vecs[i].tk, vecs[i].tgt, vecs[i].pt, vecs[i].ppc);
      #1;
      chk($sformatf("v%0d.predTaken", i), {31'd0, predTaken}, {31'd0, vecs[i].e_pt});
      chk($sformatf("v%0d.predPC", i), predPC, vecs[i].e_ppc);
      chk($sformatf("v%0d.mispredict", i), {31'd0, mispredict}, {31'd0, vecs[i].e_misp});
      chk($sformatf("v%0d.redirectPC", i), redirectPC, vecs[i].e_redir);
      chk($sformatf("v%0d.br_cnt", i), br_cnt, vecs[i].e_br);
      chk($sformatf("v%0d.miss_cnt", i), miss_cnt, vecs[i].e_miss);
    end

    // Stalled mispredicting branch: nothing may change until the stall drops
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(32'h300, 1, 1, 32'h300, 1, 1, 1, 32'h700, 0, 32'h304);
      #1;
      chk($sformatf("stall%0d.mispredict", k), {31'd0, mispredict}, 32'd0);
      chk($sformatf("stall%0d.predTaken", k), {31'd0, predTaken}, 32'd0);
      chk($sformatf("stall%0d.br_cnt", k), br_cnt, 32'd12);
      chk($sformatf("stall%0d.miss_cnt", k), miss_cnt, 32'd10);
    end
    @(negedge clk);
    drive(32'h300, 1, 0, 32'h300, 1, 1, 1, 32'h700, 0, 32'h304);
    #1;
    chk("release.mispredict", {31'd0, mispredict}, 32'd1);
    chk("release.redirectPC", redirectPC, 32'h700);
    @(negedge clk);
    drive(32'h300, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);
    #1;
    chk("release.br_cnt", br_cnt, 32'd13);
    chk("release.miss_cnt", miss_cnt, 32'd11);
    chk("release.predTaken", {31'd0, predTaken}, 32'd1);
    chk("release.predPC", predPC, 32'h700);

    // miss_cnt wrap from all-ones
    @(negedge clk);
    force dut.miss_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.miss_cnt_q;
    drive(32'h300, 1, 0, 32'h300, 1, 1, 0, 32'h700, 1, 32'h700);
    #1;
    chk("wrap.pre_miss_cnt", miss_cnt, 32'hFFFF_FFFF);
    chk("wrap.mispredict", {31'd0, mispredict}, 32'd1);
    @(negedge clk);
    drive(32'h300, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);
    #1;
    chk("wrap.miss_cnt", miss_cnt, 32'd0);
    chk("wrap.br_cnt", br_cnt, 32'd14);
    chk("wrap.predTaken", {31'd0, predTaken}, 32'd0);

    // Reset coinciding with an allocating update: update must be discarded
    @(negedge clk);
    rst = 1'b1;
    drive(32'h40, 1, 0, 32'h40, 1, 1, 1, 32'h900, 0, 32'h44);
    @(negedge clk);
    rst = 1'b0;
    drive(32'h40, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);
    #1;
    chk("midrst.br_cnt", br_cnt, 32'd0);
    chk("midrst.miss_cnt", miss_cnt, 32'd0);
    chk("midrst.predTaken40", {31'd0, predTaken}, 32'd0);
    chk("midrst.predPC40", predPC, 32'h44);
    pc_IF = 32'h300;
    #1;
    chk("midrst.predTaken300", {31'd0, predTaken}, 32'd0);
    chk("midrst.predPC300", predPC, 32'h304);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
